// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC, IMEM word addressing and the IF/ID register.
// Optional perf counters are enabled with `define FETCH_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 128,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        FetchFault,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
);

  localparam logic [29:0] DEPTH_W = 30'(IMEM_DEPTH);

  logic [31:0] pc_plus4;
  logic        in_range;

  assign ImemAddress = {2'b00, PC[31:2]};
  assign pc_plus4    = PC + 32'd4;
  assign in_range    = PC[31:2] < DEPTH_W;

  always_ff @(posedge clk) begin
    if (reset) begin
      PC            <= RESET_PC;
      IF_ID_Instr   <= NOP_WORD;
      IF_ID_PCPlus4 <= 32'h0;
      IF_ID_Valid   <= 1'b0;
      FetchFault    <= 1'b0;
    end else if (BranchTaken) begin
      // wrong-path word is dropped; misaligned targets are forced aligned
      PC          <= BranchTarget & ~32'h3;
      IF_ID_Instr <= NOP_WORD;
      IF_ID_Valid <= 1'b0;
      if (|BranchTarget[1:0])
        FetchFault <= 1'b1;
    end else if (!Stall) begin
      PC            <= pc_plus4;
      IF_ID_PCPlus4 <= pc_plus4;
      if (in_range) begin
        IF_ID_Instr <= ImemInstruction;
        IF_ID_Valid <= 1'b1;
      end else begin
        IF_ID_Instr <= NOP_WORD;
        IF_ID_Valid <= 1'b0;
        FetchFault  <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_load;
  logic stall_hold;

  assign fetch_load = !BranchTaken && !Stall && in_range;
  assign stall_hold = !BranchTaken && Stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      FetchCount <= 32'h0;
      StallCount <= 32'h0;
    end else begin
      if (fetch_load)
        FetchCount <= FetchCount + 32'd1;
      if (stall_hold)
        StallCount <= StallCount + 32'd1;
    end
  end
`else
  assign FetchCount = 32'h0;
  assign StallCount = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized self-checking bench for instruction_fetch_unit against a
// transaction-level fetch model with its own PC and IMEM image.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] ImemAddress;
  logic [31:0] ImemInstruction;
  logic [31:0] PC;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        FetchFault;
  logic [31:0] FetchCount;
  logic [31:0] StallCount;

  logic [31:0] imem [128];

  logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_sc;
  logic        m_valid, m_fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .Stall(Stall),
    .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget),
    .ImemAddress(ImemAddress),
    .ImemInstruction(ImemInstruction),
    .PC(PC),
    .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_Valid(IF_ID_Valid),
    .FetchFault(FetchFault),
    .FetchCount(FetchCount),
    .StallCount(StallCount)
  );

  // out-of-range reads return junk so a leaked word is visible
  always_comb begin
    ImemInstruction = 32'hDEAD_BEEF;
    if (ImemAddress < 32'd128)
      ImemInstruction = imem[ImemAddress[6:0]];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic st,
                            input logic bt, input logic [31:0] tgt);
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_fault = 0; m_fc = 0; m_sc = 0;
    end else if (bt) begin
      m_pc = {tgt[31:2], 2'b00};
      m_instr = 0;
      m_valid = 0;
      if (tgt % 4 != 0) m_fault = 1;
    end else if (st) begin
      m_sc++;
    end else begin
      if (m_pc / 4 >= 128) begin
        m_instr = 0; m_valid = 0; m_fault = 1;
      end else begin
        m_instr = imem[m_pc / 4];
        m_valid = 1;
        m_fc++;
      end
      m_pc4 = m_pc + 4;
      m_pc = m_pc + 4;
    end
  endtask

  task automatic compare_all();
    check("pc", PC, m_pc);
    check("imem_addr", ImemAddress, m_pc / 4);
    check("instr", IF_ID_Instr, m_instr);
    check("valid", 32'(IF_ID_Valid), 32'(m_valid));
    check("fault", 32'(FetchFault), 32'(m_fault));
    if (m_valid) check("pc4", IF_ID_PCPlus4, m_pc4);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", FetchCount, m_fc);
    check("stall_cnt", StallCount, m_sc);
`else
    check("fetch_cnt", FetchCount, 32'h0);
    check("stall_cnt", StallCount, 32'h0);
`endif
  endtask

  task automatic cyc(input logic rst, input logic st,
                     input logic bt, input logic [31:0] tgt);
    @(negedge clk);
    reset = rst; Stall = st; BranchTaken = bt; BranchTarget = tgt;
    @(posedge clk);
    model_step(rst, st, bt, tgt);
    #1 compare_all();
  endtask

  initial begin
    logic [31:0] sc0, tgt;
    int r;
    for (int i = 0; i < 128; i++) imem[i] = $urandom;
    imem[0] = 32'h00C5A020;
    imem[1] = 32'h0064A822;
    reset = 1; Stall = 0; BranchTaken = 0; BranchTarget = 0;

    // reset held two cycles
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("rst_pc4", IF_ID_PCPlus4, 32'h0);
    check("rst_instr", IF_ID_Instr, 32'h0);

    // first fetch and sequential stream
    cyc(0, 0, 0, 0);
    check("t1_instr", IF_ID_Instr, 32'h00C5A020);
    check("t1_pc4", IF_ID_PCPlus4, 32'h4);
    check("t1_pc", PC, 32'h4);
    cyc(0, 0, 0, 0);
    check("t2_instr", IF_ID_Instr, 32'h0064A822);

    // stall three cycles at PC=8
    sc0 = StallCount;
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    check("t3_pc", PC, 32'h8);
    check("t3_instr", IF_ID_Instr, 32'h0064A822);
`ifdef FETCH_PERF_CNT_EN
    check("t3_scnt", StallCount - sc0, 32'd3);
`endif
    cyc(0, 0, 0, 0);
    check("t3_rel", IF_ID_Instr, imem[2]);
    cyc(0, 0, 0, 0);
    check("t2_pc", PC, 32'h10);

    // branch with simultaneous stall at PC=8
    cyc(0, 0, 1, 32'h8);
    cyc(0, 1, 1, 32'h18);
    check("t4_pc", PC, 32'h18);
    check("t4_valid", 32'(IF_ID_Valid), 32'h0);
    cyc(0, 0, 0, 0);
    check("t4_next", IF_ID_Instr, imem[6]);

    // misaligned target and out-of-range fetch
    cyc(0, 0, 1, 32'h1E);
    check("t5_pc", PC, 32'h1C);
    check("t5_fault", 32'(FetchFault), 32'h1);
    cyc(0, 0, 1, 32'h200);
    cyc(0, 0, 0, 0);
    check("t5_oor_pc", PC, 32'h204);
    check("t5_oor_valid", 32'(IF_ID_Valid), 32'h0);

    // reset during a redirect with fault set
    cyc(1, 1, 1, 32'h33);
    check("t6_pc", PC, 32'h0);
    check("t6_fault", 32'(FetchFault), 32'h0);

    // wrap at the top of the address space
    cyc(0, 0, 1, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("wrap_pc", PC, 32'h0);
    cyc(0, 0, 0, 0);
    check("wrap_instr", IF_ID_Instr, imem[0]);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 9))
        0: tgt = $urandom_range(0, 32'h240);
        1: tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: tgt = 32'($urandom_range(0, 140)) << 2;
      endcase
      cyc(r < 2, $urandom_range(0, 3) == 0, r >= 2 && r < 15, tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
